// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and the
// sizing helpers used to dimension the shared hold timer.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 32'd0;
        while ((32'd1 << width) < value) begin
            width = width + 32'd1;
        end
        return width;
    endfunction

    // The timer holds values up to max(high, gap) - 1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned high_cycles,
                                                input int unsigned gap_cycles);
        int unsigned longest;
        int unsigned width;
        longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        width   = clog2(longest);
        return (width == 32'd0) ? 32'd1 : width;
    endfunction

endpackage

// File: rtl/pulse_stretcher_hold_timer.sv
// Loadable down-counter shared by the HIGH and GAP phases; the zero flag is
// registered so the FSM never sees a combinational compare.
module pulse_stretcher_hold_timer
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         srst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         zero_q;

    // Next count: flush, load, or count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (srst_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register and its zero flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle events into HIGH_CYCLES-wide pulses separated by at
// least GAP_CYCLES low cycles, queueing events that arrive meanwhile.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk_148Mhz,
    input  logic              reset_n,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned TIMER_W = timer_width(HIGH_CYCLES, GAP_CYCLES);
    localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 32'd1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 32'd1);
    localparam logic [PEND_W-1:0]  PEND_MAX  = '1;

    state_t              state_q, state_d;
    logic                level_q, level_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                load_s;
    logic [TIMER_W-1:0]  load_val_s;
    logic                timer_zero_s;
    logic [PEND_W-1:0]   pend_queued_s;
    logic                ovf_queued_s;

    pulse_stretcher_hold_timer #(
        .W (TIMER_W)
    ) u_hold_timer (
        .clk_i      (clk_148Mhz),
        .rst_ni     (reset_n),
        .srst_i     (clear),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .zero_o     (timer_zero_s)
    );

    // Effect of queueing the current pulse_in: count it, or drop it when saturated.
    always_comb begin
        pend_queued_s = pend_q;
        ovf_queued_s  = ovf_q;
        if (pulse_in) begin
            if (pend_q == PEND_MAX) begin
                ovf_queued_s = 1'b1;
            end else begin
                pend_queued_s = pend_q + PEND_W'(1);
            end
        end else begin
            pend_queued_s = pend_q;
        end
    end

    // Next-state logic; clear overrides every other activity.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q;
        load_s     = 1'b0;
        load_val_s = HIGH_LOAD;
        if (clear) begin
            state_d = ST_IDLE;
            level_d = 1'b0;
            busy_d  = 1'b0;
            pend_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state_d    = ST_HIGH;
                        level_d    = 1'b1;
                        busy_d     = 1'b1;
                        load_s     = 1'b1;
                        load_val_s = HIGH_LOAD;
                    end else begin
                        level_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
                ST_HIGH: begin
                    pend_d = pend_queued_s;
                    ovf_d  = ovf_queued_s;
                    if (timer_zero_s) begin
                        state_d    = ST_GAP;
                        level_d    = 1'b0;
                        load_s     = 1'b1;
                        load_val_s = GAP_LOAD;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
                ST_GAP: begin
                    if (!timer_zero_s) begin
                        pend_d = pend_queued_s;
                        ovf_d  = ovf_queued_s;
                    end else if ((pend_q != '0) || pulse_in) begin
                        // A new arrival here replaces the consumed queued event.
                        state_d    = ST_HIGH;
                        level_d    = 1'b1;
                        load_s     = 1'b1;
                        load_val_s = HIGH_LOAD;
                        if ((pend_q != '0) && !pulse_in) begin
                            pend_d = pend_q - PEND_W'(1);
                        end else begin
                            pend_d = pend_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        level_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                    busy_d  = 1'b0;
                    pend_d  = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk_148Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed, table-driven bench for pulse_stretcher with default parameters;
// vector i drives inputs for one cycle and checks the outputs after that edge.
module tb_pulse_stretcher;

    typedef struct packed {
        logic       pin;
        logic       clr;
        logic       lvl;
        logic       bsy;
        logic [2:0] pend;
        logic       ovf;
    } vec_t;

    logic       clk_148Mhz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       pulse_in   = 1'b0;
    logic       clear      = 1'b0;
    logic       level_out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pulse_stretcher #(
        .HIGH_CYCLES (16),
        .GAP_CYCLES  (4),
        .PEND_W      (3)
    ) dut (
        .clk_148Mhz (clk_148Mhz),
        .reset_n    (reset_n),
        .pulse_in   (pulse_in),
        .clear      (clear),
        .level_out  (level_out),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk_148Mhz = ~clk_148Mhz;

    task automatic add(input int n, input int pin, input int clr, input int lvl,
                       input int bsy, input int pend, input int ovf);
        vec_t v;
        v.pin  = 1'(pin);
        v.clr  = 1'(clr);
        v.lvl  = 1'(lvl);
        v.bsy  = 1'(bsy);
        v.pend = 3'(pend);
        v.ovf  = 1'(ovf);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic pin, input logic clr);
        pulse_in = pin;
        clear    = clr;
        @(posedge clk_148Mhz);
        #1;
        pulse_in = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        int highs;

        // Single event.
        add(1, 1,0, 1,1,0,0); add(15, 0,0, 1,1,0,0); add(4, 0,0, 0,1,0,0); add(3, 0,0, 0,0,0,0);
        // Back-to-back events at offsets 0, 2, 4.
        add(1, 1,0, 1,1,0,0); add(1, 0,0, 1,1,0,0);
        add(1, 1,0, 1,1,1,0); add(1, 0,0, 1,1,1,0);
        add(1, 1,0, 1,1,2,0); add(11, 0,0, 1,1,2,0); add(4, 0,0, 0,1,2,0);
        add(16, 0,0, 1,1,1,0); add(4, 0,0, 0,1,1,0);
        add(16, 0,0, 1,1,0,0); add(4, 0,0, 0,1,0,0); add(2, 0,0, 0,0,0,0);
        // Saturation: nine events during the first pulse, eight pulses out.
        add(1, 1,0, 1,1,0,0);
        for (int k = 1; k <= 7; k++) add(1, 1,0, 1,1,k,0);
        add(1, 1,0, 1,1,7,1); add(7, 0,0, 1,1,7,1); add(4, 0,0, 0,1,7,1);
        for (int k = 1; k <= 7; k++) begin
            add(16, 0,0, 1,1,7-k,1); add(4, 0,0, 0,1,7-k,1);
        end
        add(2, 0,0, 0,0,0,1);
        // Clear in the fifth HIGH cycle with pending=3, overflow=1 and a coincident pulse.
        add(1, 1,0, 1,1,0,1); add(1, 1,0, 1,1,1,1); add(1, 1,0, 1,1,2,1); add(1, 1,0, 1,1,3,1);
        add(1, 1,1, 0,0,0,0); add(20, 0,0, 0,0,0,0);
        // Final gap cycle with pending=1 plus a new event: no extra gap, pending stays 1.
        add(1, 1,0, 1,1,0,0); add(1, 1,0, 1,1,1,0); add(14, 0,0, 1,1,1,0); add(4, 0,0, 0,1,1,0);
        add(1, 1,0, 1,1,1,0); add(15, 0,0, 1,1,1,0); add(4, 0,0, 0,1,1,0);
        add(16, 0,0, 1,1,0,0); add(4, 0,0, 0,1,0,0); add(2, 0,0, 0,0,0,0);
        // Final gap cycle with pending=0 plus a new event: starts directly.
        add(1, 1,0, 1,1,0,0); add(15, 0,0, 1,1,0,0); add(4, 0,0, 0,1,0,0);
        add(1, 1,0, 1,1,0,0); add(15, 0,0, 1,1,0,0); add(4, 0,0, 0,1,0,0); add(2, 0,0, 0,0,0,0);

        // Reset held for three cycles.
        repeat (3) @(posedge clk_148Mhz);
        #1;
        check("reset_outs", 0, {26'd0, level_out, busy, pending, overflow}, 32'd0);
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("idle_outs", 0, {26'd0, level_out, busy, pending, overflow}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].pin, vecs[i].clr);
            check("vec", i, {26'd0, level_out, busy, pending, overflow},
                  {26'd0, vecs[i].lvl, vecs[i].bsy, vecs[i].pend, vecs[i].ovf});
        end

        // Async reset mid-pulse, between clock edges.
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        check("pre_areset_level", 0, {31'd0, level_out}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_level", 0, {31'd0, level_out}, 32'd0);
        check("areset_busy", 0, {31'd0, busy}, 32'd0);
        @(posedge clk_148Mhz);
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        check("post_areset_idle", 0, {26'd0, level_out, busy, pending, overflow}, 32'd0);

        // After reset release a single event behaves normally.
        step(1'b1, 1'b0);
        check("post_areset_latency", 0, {31'd0, level_out}, 32'd1);
        highs = 1;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b0);
            highs += int'(level_out);
        end
        check("post_areset_width", 0, 32'(highs), 32'd16);
        check("post_areset_busy", 0, {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses into clean, level-held output pulses. Each output pulse is high for a fixed number of cycles and is followed by a guaranteed low gap.
- This is the reverse of the button rising-edge detector. Every emitted pulse has a distinct 0->1 edge that a downstream edge detector, LED, or slow peripheral is guaranteed to see.
- Sits between the VGA/game logic, which issues one-cycle events (obstacle hit, score tick), and the board outputs. Events arriving while an output pulse is in progress are queued in a saturating counter, not lost.

Parameters:
- HIGH_CYCLES, 16, cycles level_out is held high per event (>=1).
- GAP_CYCLES, 4, minimum low cycles between consecutive output pulses (>=1).
- PEND_W, 3, width of the pending-event counter; max queued events = 2^PEND_W-1.

Ports:
- clk_148Mhz  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous reset, active-low.
- pulse_in  input  1  one-cycle event request, synchronous to clk_148Mhz.
- clear  input  1  synchronous flush: abort current pulse, drop queue, clear overflow.
- level_out  output  1  stretched pulse output (registered).
- busy  output  1  high whenever state != IDLE (registered).
- pending  output  PEND_W  number of queued, not-yet-emitted events.
- overflow  output  1  sticky: an event was dropped because pending was saturated.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, level_out=0, busy=0, pending=0, overflow=0, timer=0.
- Timer is a down-counter of width clog2(max(HIGH_CYCLES,GAP_CYCLES)).
- FSM states are IDLE, HIGH and GAP; all outputs are registered.
- IDLE:
  - pulse_in=1 sampled at edge k -> from edge k+1: state=HIGH, level_out=1, timer=HIGH_CYCLES-1.
  - Latency is exactly 1 cycle.
- HIGH:
  - Timer decrements each cycle.
  - At timer==0: next state GAP, level_out=0, timer=GAP_CYCLES-1.
  - level_out is high for exactly HIGH_CYCLES cycles.
- GAP:
  - Timer decrements each cycle.
  - At timer==0, if pending>0 or pulse_in=1: go to HIGH (level_out=1, timer=HIGH_CYCLES-1) and consume one event.
  - Otherwise go to IDLE.
  - level_out is low for exactly GAP_CYCLES cycles between back-to-back pulses.
- Queueing: pulse_in=1 in HIGH, or in GAP before the final gap cycle, gives pending+1.
  - If pending is already 2^PEND_W-1, the event is dropped and overflow is set to 1 (sticky).
- Queueing, final GAP cycle:
  - pulse_in=1 with pending=0 starts the next pulse directly; pending stays 0.
  - pulse_in=1 with pending>0: the queued event is consumed and the new one is queued, so pending is unchanged.
  - pending>0 with pulse_in=0 gives pending-1.
- Events are emitted in order of arrival; one output pulse per accepted event; throughput is one event per HIGH_CYCLES+GAP_CYCLES cycles.
- clear=1 (synchronous) has priority over pulse_in and all FSM activity. Next cycle: state=IDLE, level_out=0, busy=0, pending=0, overflow=0. A pulse_in in the same cycle is discarded.
- busy=1 in HIGH and GAP; busy=0 only in IDLE. busy falls on the same edge that enters IDLE.
- A reset assertion mid-pulse forces level_out low immediately (async). After reset_n deasserts, the block is in IDLE and ignores history.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_HIGH=2'd1, ST_GAP=2'd2;
  - a clog2 helper function used for the timer width.
- Natural sub-module: hold_timer. It is a loadable down-counter with load value input, load strobe, and a registered zero flag. It is instantiated once and shared by the HIGH and GAP phases.
- FSM and pending counter stay in pulse_stretcher.

Test Plan:
All cases use defaults (HIGH_CYCLES=16, GAP_CYCLES=4, PEND_W=3).
- Reset and single event: hold reset_n=0 for 3 cycles, release, then pulse_in at cycle 10 -> level_out=0 until cycle 11, then high for cycles 11-26, low from cycle 27; busy high 11-30; pending stays 0.
- Back-to-back: pulses at cycles 10, 12, 14 -> pending goes 1, 2 by cycle 15. Three output pulses, each 16 high, separated by exactly 4 low cycles. pending returns to 0 when the third pulse starts; busy drops after the third gap.
- Saturation: 9 pulses while the first output is high -> pending saturates at 7 and overflow=1 from the 9th pulse. Exactly 8 output pulses total; overflow stays 1 afterwards.
- Final-gap coincidence: pending=1 and pulse_in on the last GAP cycle -> next pulse starts with no extra gap; pending stays 1.
- Clear mid-pulse: clear at cycle 5 of HIGH with pending=3 and overflow=1 -> next cycle level_out=0, busy=0, pending=0, overflow=0. A pulse_in coincident with clear produces no output.
- Async reset mid-pulse: drop reset_n between clock edges while level_out=1 -> level_out goes 0 without waiting for a clock edge. The next pulse_in after release behaves like the single-event case.
